multdiv_sequencer: RTL and testbench

Multi-cycle sequencer that lets the single-cycle processor run mul/div on the shared iterative multdiv unit. It detects an R-type mul or div, freezes the PC and pipeline, and pulses the start strobe for the operation. It then waits for the result, or times out, and produces one register-file writeback. On overflow, divide-by-zero or timeout, that writeback goes to the status register $r30 with the exception code.

---
 rtl/multdiv_sequencer_pkg.sv | 38 +++
 rtl/md_timeout_counter.sv | 27 ++
 rtl/multdiv_sequencer.sv | 151 +++++++++++++++
 tb/tb_multdiv_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// Shared encodings for the mul/div sequencer: decode constants, status codes,
// FSM states and the writeback payload.
package multdiv_sequencer_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] FUNC_MUL  = 5'b00110;
  localparam logic [4:0] FUNC_DIV  = 5'b00111;

  localparam logic [DATA_W-1:0] RSTATUS_ADD  = 32'd1;
  localparam logic [DATA_W-1:0] RSTATUS_ADDI = 32'd2;
  localparam logic [DATA_W-1:0] RSTATUS_SUB  = 32'd3;
  localparam logic [DATA_W-1:0] RSTATUS_MUL  = 32'd4;
  localparam logic [DATA_W-1:0] RSTATUS_DIV  = 32'd5;

  localparam logic [REG_W-1:0] STATUS_REG = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  typedef struct packed {
    logic              en;
    logic [REG_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_t;

  // Status code written to $r30 when the operation faults or times out
  function automatic logic [DATA_W-1:0] exc_code(input logic is_div);
    return is_div ? RSTATUS_DIV : RSTATUS_MUL;
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Counts WAIT cycles and flags the last allowed cycle before a forced timeout.
module md_timeout_counter #(
  parameter int unsigned TIMEOUT   = 40,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_limit_c
);

  logic [TIMEOUT_W-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + TIMEOUT_W'(1);
    end
  end

  assign at_limit_c = (count_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Freezes the core around a mul/div, drives the multdiv start strobe and
// produces a single register-file writeback (result or $r30 status code).
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 40,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_in,
  input  logic [4:0]  rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        busy,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  state_t     state_q, state_d;
  logic       is_div_q, is_div_d;
  logic [4:0] rd_q, rd_d;
  logic       ctrl_mult_q, ctrl_mult_d;
  logic       ctrl_div_q, ctrl_div_d;
  logic       busy_q, busy_d;
  logic       timeout_err_q, timeout_err_d;
  wb_t        wb_q, wb_d;

  logic mul_hit_c, div_hit_c;
  logic cnt_clear_c, cnt_enable_c, at_limit_c;

  assign mul_hit_c = issue_valid && (opcode == OPC_RTYPE) && (alu_in == FUNC_MUL);
  assign div_hit_c = issue_valid && (opcode == OPC_RTYPE) && (alu_in == FUNC_DIV);

  md_timeout_counter #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear_c),
    .enable     (cnt_enable_c),
    .at_limit_c (at_limit_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      is_div_q      <= 1'b0;
      rd_q          <= '0;
      ctrl_mult_q   <= 1'b0;
      ctrl_div_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      wb_q          <= '0;
    end else begin
      state_q       <= state_d;
      is_div_q      <= is_div_d;
      rd_q          <= rd_d;
      ctrl_mult_q   <= ctrl_mult_d;
      ctrl_div_q    <= ctrl_div_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      wb_q          <= wb_d;
    end
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d       = state_q;
    is_div_d      = is_div_q;
    rd_d          = rd_q;
    ctrl_mult_d   = 1'b0;
    ctrl_div_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    wb_d          = wb_q;
    wb_d.en       = 1'b0;
    cnt_clear_c   = 1'b0;
    cnt_enable_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mul_hit_c || div_hit_c) begin
          rd_d        = rd;
          is_div_d    = div_hit_c;
          ctrl_mult_d = mul_hit_c;
          ctrl_div_d  = div_hit_c;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        cnt_clear_c = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_enable_c = 1'b1;
        // A result arriving on the limit cycle still wins over the timeout
        if (md_resultRDY) begin
          state_d = ST_WB;
          if (md_exception) begin
            wb_d = '{en: 1'b1, idx: STATUS_REG, data: exc_code(is_div_q)};
          end else begin
            wb_d = '{en: (rd_q != 5'd0), idx: rd_q, data: md_result};
          end
        end else if (at_limit_c) begin
          state_d       = ST_WB;
          timeout_err_d = 1'b1;
          wb_d          = '{en: 1'b1, idx: STATUS_REG, data: exc_code(is_div_q)};
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Stall must act in the detect cycle itself so the PC never advances
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      case (state_q)
        ST_IDLE:  stall = mul_hit_c || div_hit_c;
        ST_START: stall = 1'b1;
        ST_WAIT:  stall = 1'b1;
        default:  stall = 1'b0;
      endcase
    end
  end

  assign ctrl_MULT   = ctrl_mult_q;
  assign ctrl_DIV    = ctrl_div_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign wb_en       = wb_q.en;
  assign wb_reg      = wb_q.idx;
  assign wb_data     = wb_q.data;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer against a transaction-level model.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 40;
  localparam int NEVER   = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  opcode = '0;
  logic [4:0]  alu_in = '0;
  logic [4:0]  rd = '0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        ctrl_MULT, ctrl_DIV, stall, busy, wb_en, timeout_err;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_terr = 1'b0;

  multdiv_sequencer #(.TIMEOUT(TIMEOUT), .TIMEOUT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .opcode       (opcode),
    .alu_in       (alu_in),
    .rd           (rd),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .stall        (stall),
    .busy         (busy),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One mul/div transaction. d = WAIT-cycle index of the RDY pulse (0 = first WAIT cycle).
  task automatic run_op(input bit is_div, input logic [4:0] dst, input int d,
                        input logic [31:0] res, input bit exc, input bit rdy_in_start);
    int n_mul = 0, n_div = 0, n_wb = 0, n_stall = 0;
    int start_cyc = -1, wb_cyc = -1, exp_wb_cyc;
    bit timed_out, fault, wb_ok_en, wb_busy;
    logic [4:0]  exp_reg, got_reg;
    logic [31:0] exp_data, got_data;
    logic got_en;
    timed_out  = (d > TIMEOUT - 1);
    fault      = timed_out || exc;
    exp_wb_cyc = 3 + (timed_out ? TIMEOUT - 1 : d);
    exp_reg    = fault ? 5'd30 : dst;
    exp_data   = fault ? (is_div ? 32'd5 : 32'd4) : res;
    wb_ok_en   = fault ? 1'b1 : (dst != 5'd0);
    if (timed_out) model_terr = 1'b1;
    got_en = 1'b0; got_reg = '0; got_data = '0; wb_busy = 1'b0;

    for (int cyc = 0; cyc < exp_wb_cyc + 6 && wb_cyc < 0; cyc++) begin
      @(posedge clock); #1;
      if (cyc == 0) begin
        issue_valid = 1'b1;
        opcode      = 5'd0;
        alu_in      = is_div ? 5'd7 : 5'd6;
        rd          = dst;
      end
      md_resultRDY = (cyc == 2 + d) || (rdy_in_start && cyc == 1);
      md_exception = (cyc == 2 + d) ? exc : 1'($urandom);
      md_result    = (cyc == 2 + d) ? res : $urandom;
      @(negedge clock);
      n_mul += int'(ctrl_MULT);
      n_div += int'(ctrl_DIV);
      n_wb  += int'(wb_en);
      if (ctrl_MULT || ctrl_DIV) start_cyc = cyc;
      if (stall) n_stall++;
      else if (cyc > 0) begin
        wb_cyc = cyc; got_en = wb_en; got_reg = wb_reg; got_data = wb_data; wb_busy = busy;
      end
    end
    issue_valid  = 1'b0;
    md_resultRDY = 1'b0;

    check("wb_cycle", wb_cyc, exp_wb_cyc);
    check("stall_cycles", n_stall, exp_wb_cyc);
    check("mul_pulses", n_mul, is_div ? 0 : 1);
    check("div_pulses", n_div, is_div ? 1 : 0);
    check("start_cycle", start_cyc, 1);
    check("wb_pulses", n_wb, wb_ok_en ? 1 : 0);
    check("wb_en", got_en, wb_ok_en);
    check("wb_reg", got_reg, exp_reg);
    check("wb_data", got_data, exp_data);
    check("busy_in_wb", wb_busy, 1);
    check("timeout_err", timeout_err, model_terr);
  endtask

  // Non-mul/div traffic and stray RDY pulses must leave the sequencer quiet
  task automatic idle_cycles(input int n);
    int bad = 0;
    repeat (n) begin
      @(posedge clock); #1;
      issue_valid  = 1'($urandom);
      opcode       = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      alu_in       = 5'($urandom_range(4, 9));
      rd           = 5'($urandom);
      if (issue_valid && opcode == 5'd0 && (alu_in == 5'd6 || alu_in == 5'd7)) issue_valid = 1'b0;
      md_resultRDY = 1'($urandom);
      md_result    = $urandom;
      @(negedge clock);
      if (stall || busy || wb_en || ctrl_MULT || ctrl_DIV) bad++;
    end
    issue_valid  = 1'b0;
    md_resultRDY = 1'b0;
    check("idle_quiet", bad, 0);
  endtask

  initial begin
    int bad;
    // Reset state, with a live mul instruction on the inputs
    issue_valid = 1'b1; opcode = 5'd0; alu_in = 5'd6; rd = 5'd9;
    #3;
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    check("rst_wb", {wb_en, wb_reg, wb_data}, 0);
    check("rst_terr", timeout_err, 0);
    issue_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    run_op(1'b0, 5'd5, 9, 32'h0000_0042, 1'b0, 1'b0);
    run_op(1'b1, 5'd7, 3, $urandom, 1'b1, 1'b0);
    run_op(1'b0, 5'd0, 2, 32'h0000_1234, 1'b0, 1'b0);
    run_op(1'b1, 5'd9, 4, $urandom, 1'b0, 1'b1);
    run_op(1'b0, 5'd11, TIMEOUT - 1, $urandom, 1'b0, 1'b0);
    run_op(1'b1, 5'd12, TIMEOUT - 2, $urandom, 1'b1, 1'b0);
    run_op(1'b0, 5'd3, NEVER, $urandom, 1'b0, 1'b0);
    idle_cycles(6);
    run_op(1'b1, 5'd4, 0, $urandom, 1'b0, 1'b0);

    // Reset dropped while waiting on the multdiv unit
    @(posedge clock); #1;
    issue_valid = 1'b1; opcode = 5'd0; alu_in = 5'd6; rd = 5'd12;
    repeat (6) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    model_terr = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    check("mid_rst_wb", {wb_en, wb_reg, wb_data}, 0);
    check("mid_rst_terr", timeout_err, 0);
    @(negedge clock); issue_valid = 1'b0;
    @(negedge clock); reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      md_resultRDY = (i == 1);
      md_result    = $urandom;
      @(negedge clock);
      if (wb_en || busy || stall) bad++;
    end
    md_resultRDY = 1'b0;
    check("late_rdy_ignored", bad, 0);

    run_op(1'b0, 5'd13, 1, $urandom, 1'b0, 1'b0);
    run_op(1'b1, 5'd14, 2, $urandom, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      int sel, d;
      sel = $urandom_range(0, 9);
      if (sel < 6)       d = $urandom_range(0, 12);
      else if (sel < 8)  d = TIMEOUT - 1 - $urandom_range(0, 1);
      else if (sel == 8) d = NEVER;
      else               d = $urandom_range(13, 30);
      run_op(1'($urandom), 5'($urandom), d, $urandom,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
